// File: rtl/mem_stage.sv
// Memory-access stage: steers loads/stores onto a req/ack data bus, stalls the
// pipeline until the access completes, and extends load data for write-back.
module mem_stage #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_waddr_reg_i,
  input  logic        mem_we_reg_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [7:0]  mem_aluop_i,
  input  logic [31:0] mem_mem_addr_i,
  input  logic [31:0] mem_reg2_i,
  output logic [4:0]  wb_waddr_reg_o,
  output logic        wb_we_reg_o,
  output logic [31:0] wb_wdata_o,
  output logic        stallreq_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_sel_o,
  output logic [31:0] dbus_wdata_o,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t      state_q, state_d;
  logic        req_q, req_d, we_q, we_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, cnt_q, cnt_d;
  logic [3:0]  sel_q, sel_d;

  logic        is_ld, is_st, is_mem, sext, misal, tmo;
  size_t       sz;
  logic [1:0]  off;
  logic [3:0]  sel_c;
  logic [31:0] st_data, ld_data;

  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    sext  = 1'b0;
    sz    = SZ_W;
    case (mem_aluop_i)
      8'hE0: begin is_ld = 1'b1; sz = SZ_B; sext = 1'b1; end
      8'hE1: begin is_ld = 1'b1; sz = SZ_H; sext = 1'b1; end
      8'hE3: begin is_ld = 1'b1; sz = SZ_W; end
      8'hE4: begin is_ld = 1'b1; sz = SZ_B; end
      8'hE5: begin is_ld = 1'b1; sz = SZ_H; end
      8'hE8: begin is_st = 1'b1; sz = SZ_B; end
      8'hE9: begin is_st = 1'b1; sz = SZ_H; end
      8'hEB: begin is_st = 1'b1; sz = SZ_W; end
      default: ;
    endcase
  end

  assign is_mem = is_ld | is_st;
  assign off    = mem_mem_addr_i[1:0];
  assign misal  = is_mem && (((sz == SZ_H) && off[0]) || ((sz == SZ_W) && (off != 2'b00)));
  assign tmo    = (TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1));

  // Big-endian lanes: byte offset 0 sits in bits 31:24.
  always_comb begin
    sel_c   = 4'b1111;
    st_data = mem_reg2_i;
    case (sz)
      SZ_B: begin
        sel_c   = 4'b1000 >> off;
        st_data = {4{mem_reg2_i[7:0]}};
      end
      SZ_H: begin
        sel_c   = off[1] ? 4'b0011 : 4'b1100;
        st_data = {2{mem_reg2_i[15:0]}};
      end
      default: ;
    endcase
  end

  // ex_mem holds the instruction during the stall, so offset/op still apply in DONE.
  always_comb begin
    ld_data = rdata_q;
    case (sz)
      SZ_B: begin
        logic [7:0] b;
        case (off)
          2'd0:    b = rdata_q[31:24];
          2'd1:    b = rdata_q[23:16];
          2'd2:    b = rdata_q[15:8];
          default: b = rdata_q[7:0];
        endcase
        ld_data = {{24{sext & b[7]}}, b};
      end
      SZ_H: begin
        logic [15:0] h;
        h = off[1] ? rdata_q[15:0] : rdata_q[31:16];
        ld_data = {{16{sext & h[15]}}, h};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        if (is_mem && !misal) begin
          state_d = S_WAIT;
          req_d   = 1'b1;
          we_d    = is_st;
          addr_d  = {mem_mem_addr_i[31:2], 2'b00};
          sel_d   = sel_c;
          wdata_d = st_data;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_WAIT: begin
        if (dbus_ack_i) begin
          rdata_d = dbus_rdata_i;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if (tmo) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wb_waddr_reg_o = mem_waddr_reg_i;
    wb_we_reg_o    = mem_we_reg_i;
    wb_wdata_o     = mem_wdata_i;
    stallreq_o     = 1'b0;
    misalign_o     = 1'b0;
    bus_err_o      = 1'b0;
    dbus_req_o     = req_q;
    dbus_we_o      = we_q;
    dbus_addr_o    = addr_q;
    dbus_sel_o     = sel_q;
    dbus_wdata_o   = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (misal) begin
          misalign_o  = 1'b1;
          wb_we_reg_o = 1'b0;
        end else if (is_mem) begin
          stallreq_o = 1'b1;
        end
      end
      S_WAIT: stallreq_o = 1'b1;
      S_DONE: begin
        if (err_q) begin
          wb_we_reg_o = 1'b0;
          bus_err_o   = 1'b1;
        end else if (is_ld) begin
          wb_wdata_o = ld_data;
        end
      end
      default: ;
    endcase
    if (rst) begin
      wb_waddr_reg_o = '0;
      wb_we_reg_o    = 1'b0;
      wb_wdata_o     = '0;
      stallreq_o     = 1'b0;
      misalign_o     = 1'b0;
      bus_err_o      = 1'b0;
      dbus_req_o     = 1'b0;
      dbus_we_o      = 1'b0;
      dbus_addr_o    = '0;
      dbus_sel_o     = '0;
      dbus_wdata_o   = '0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: IDLE-only vector table plus bus-handshake sequences.
module tb_mem_stage;
  logic        clk, rst;
  logic [4:0]  mem_waddr_reg_i, wb_waddr_reg_o;
  logic        mem_we_reg_i, wb_we_reg_o;
  logic [31:0] mem_wdata_i, mem_mem_addr_i, mem_reg2_i, wb_wdata_o;
  logic [7:0]  mem_aluop_i;
  logic        stallreq_o, dbus_req_o, dbus_we_o, dbus_ack_i, misalign_o, bus_err_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o, dbus_rdata_i;
  logic [3:0]  dbus_sel_o;

  int checks = 0;
  int errors = 0;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .mem_waddr_reg_i(mem_waddr_reg_i), .mem_we_reg_i(mem_we_reg_i),
    .mem_wdata_i(mem_wdata_i), .mem_aluop_i(mem_aluop_i),
    .mem_mem_addr_i(mem_mem_addr_i), .mem_reg2_i(mem_reg2_i),
    .wb_waddr_reg_o(wb_waddr_reg_o), .wb_we_reg_o(wb_we_reg_o), .wb_wdata_o(wb_wdata_o),
    .stallreq_o(stallreq_o), .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
    .dbus_addr_o(dbus_addr_o), .dbus_sel_o(dbus_sel_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nop_inputs();
    mem_aluop_i     = 8'h00;
    mem_mem_addr_i  = 32'h0;
    mem_reg2_i      = 32'h0;
    mem_wdata_i     = 32'h0;
    mem_waddr_reg_i = 5'd0;
    mem_we_reg_i    = 1'b0;
    dbus_ack_i      = 1'b0;
    dbus_rdata_i    = 32'hA5A5_A5A5;
  endtask

  // Drives one memory op through the handshake; ack_at is the WAIT cycle index
  // (0-based) on which ack is returned, -1 for never.
  task automatic run_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt,
                         input int ack_at, input logic [31:0] rd,
                         output int stall_n, output int req_n, output logic stable,
                         output logic [3:0] sel, output logic we, output logic [31:0] baddr,
                         output logic [31:0] bwdata, output logic done,
                         output logic [31:0] d_wdata, output logic d_we, output logic d_err);
    int widx;
    mem_aluop_i = op; mem_mem_addr_i = addr; mem_reg2_i = rt;
    mem_wdata_i = 32'h5555_0000; mem_waddr_reg_i = 5'd9; mem_we_reg_i = 1'b1;
    widx = 0; stall_n = 0; req_n = 0; stable = 1'b1; done = 1'b0;
    sel = '0; we = 1'b0; baddr = '0; bwdata = '0; d_wdata = '0; d_we = 1'b0; d_err = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      dbus_ack_i   = dbus_req_o && (widx == ack_at);
      dbus_rdata_i = dbus_ack_i ? rd : 32'hA5A5_A5A5;
      #2;
      if (stallreq_o) stall_n++;
      if (dbus_req_o) begin
        if (req_n == 0) begin
          sel = dbus_sel_o; we = dbus_we_o; baddr = dbus_addr_o; bwdata = dbus_wdata_o;
        end else if (sel !== dbus_sel_o || we !== dbus_we_o || baddr !== dbus_addr_o ||
                     bwdata !== dbus_wdata_o) begin
          stable = 1'b0;
        end
        req_n++;
        widx++;
      end else if (stall_n > 0 && !stallreq_o) begin
        done = 1'b1; d_wdata = wb_wdata_o; d_we = wb_we_reg_o; d_err = bus_err_o;
      end
      @(posedge clk); #1;
    end
    nop_inputs();
    #2;
    chk("back_to_idle", {dbus_req_o, stallreq_o, bus_err_o}, 3'b000);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  wa;
    logic        we;
    logic        e_we;
    logic        e_mis;
  } vec_t;

  typedef struct {
    string       nm;
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] rt;
    int          ack_at;
    logic [31:0] rd;
    int          e_stall;
    int          e_req;
    logic [3:0]  e_sel;
    logic        e_bwe;
    logic [31:0] e_baddr;
    logic [31:0] e_bwdata;
    logic [31:0] e_wdata;
    logic        e_we;
    logic        e_err;
  } seq_t;

  vec_t tv[6];
  seq_t sv[9];

  initial begin
    int sn, rn;
    logic st, we, dn, dwe, derr;
    logic [3:0] sel;
    logic [31:0] ba, bw, dwd;

    tv[0] = '{8'h21, 32'h0,   32'h0000_1234, 5'd5,  1'b1, 1'b1, 1'b0};
    tv[1] = '{8'h00, 32'h103, 32'hCAFE_F00D, 5'd31, 1'b0, 1'b0, 1'b0};
    tv[2] = '{8'hE3, 32'h103, 32'h0000_0777, 5'd3,  1'b1, 1'b0, 1'b1};
    tv[3] = '{8'hE1, 32'h101, 32'h0000_0111, 5'd4,  1'b1, 1'b0, 1'b1};
    tv[4] = '{8'hEB, 32'h102, 32'h0000_0222, 5'd6,  1'b0, 1'b0, 1'b1};
    tv[5] = '{8'hE9, 32'h203, 32'h0000_0333, 5'd7,  1'b1, 1'b0, 1'b1};

    //        name    op     addr      rt            ack rdata         st rq sel     bwe baddr     bwdata        wb_wdata      we    err
    sv[0] = '{"LB",  8'hE0, 32'h101, 32'h0,        1, 32'h1180_2233, 3, 2, 4'b0100, 1'b0, 32'h100, 32'h0,        32'hFFFF_FF80, 1'b1, 1'b0};
    sv[1] = '{"LBU", 8'hE4, 32'h101, 32'h0,        1, 32'h1180_2233, 3, 2, 4'b0100, 1'b0, 32'h100, 32'h0,        32'h0000_0080, 1'b1, 1'b0};
    sv[2] = '{"LH",  8'hE1, 32'h102, 32'h0,        0, 32'h1122_8001, 2, 1, 4'b0011, 1'b0, 32'h100, 32'h0,        32'hFFFF_8001, 1'b1, 1'b0};
    sv[3] = '{"LHU", 8'hE5, 32'h300, 32'h0,        0, 32'h8001_2233, 2, 1, 4'b1100, 1'b0, 32'h300, 32'h0,        32'h0000_8001, 1'b1, 1'b0};
    sv[4] = '{"LW",  8'hE3, 32'h104, 32'h0,        0, 32'hDEAD_BEEF, 2, 1, 4'b1111, 1'b0, 32'h104, 32'h0,        32'hDEAD_BEEF, 1'b1, 1'b0};
    sv[5] = '{"SH",  8'hE9, 32'h202, 32'hAAAA_BEEF, 2, 32'h0,        4, 3, 4'b0011, 1'b1, 32'h200, 32'hBEEF_BEEF, 32'h5555_0000, 1'b1, 1'b0};
    sv[6] = '{"SB",  8'hE8, 32'h203, 32'h1234_5678, 0, 32'h0,        2, 1, 4'b0001, 1'b1, 32'h200, 32'h7878_7878, 32'h5555_0000, 1'b1, 1'b0};
    sv[7] = '{"LWTO",8'hE3, 32'h108, 32'h0,       -1, 32'h0,        5, 4, 4'b1111, 1'b0, 32'h108, 32'h0,        32'h5555_0000, 1'b0, 1'b1};
    sv[8] = '{"LWA4",8'hE3, 32'h108, 32'h0,        3, 32'h0BAD_F00D, 5, 4, 4'b1111, 1'b0, 32'h108, 32'h0,        32'h0BAD_F00D, 1'b1, 1'b0};

    // Reset state: every output forced low while rst is high.
    rst = 1'b1;
    nop_inputs();
    mem_aluop_i = 8'h21; mem_wdata_i = 32'h1234; mem_waddr_reg_i = 5'd5; mem_we_reg_i = 1'b1;
    #2;
    chk("reset_outputs", {wb_waddr_reg_o, wb_we_reg_o, wb_wdata_o, stallreq_o, dbus_req_o,
        dbus_we_o, dbus_addr_o, dbus_sel_o, dbus_wdata_o, misalign_o, bus_err_o}, '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    foreach (tv[i]) begin
      mem_aluop_i = tv[i].op; mem_mem_addr_i = tv[i].addr; mem_wdata_i = tv[i].wd;
      mem_waddr_reg_i = tv[i].wa; mem_we_reg_i = tv[i].we; mem_reg2_i = 32'hFFFF_FFFF;
      #2;
      chk($sformatf("vec%0d_out", i),
          {wb_waddr_reg_o, wb_we_reg_o, wb_wdata_o, stallreq_o, misalign_o, dbus_req_o},
          {tv[i].wa, tv[i].e_we, tv[i].wd, 1'b0, tv[i].e_mis, 1'b0});
      @(posedge clk); #3;
      chk($sformatf("vec%0d_noreq", i), {dbus_req_o, stallreq_o}, 2'b00);
      @(posedge clk); #1;
    end
    nop_inputs();

    foreach (sv[i]) begin
      run_mem(sv[i].op, sv[i].addr, sv[i].rt, sv[i].ack_at, sv[i].rd,
              sn, rn, st, sel, we, ba, bw, dn, dwd, dwe, derr);
      chk({sv[i].nm, "_done"}, dn, 1'b1);
      chk({sv[i].nm, "_stall_req"}, {sn[7:0], rn[7:0]}, {8'(sv[i].e_stall), 8'(sv[i].e_req)});
      chk({sv[i].nm, "_bus"}, {st, sel, we, ba}, {1'b1, sv[i].e_sel, sv[i].e_bwe, sv[i].e_baddr});
      if (sv[i].e_bwe) chk({sv[i].nm, "_bwdata"}, bw, sv[i].e_bwdata);
      chk({sv[i].nm, "_wb"}, {dwd, dwe, derr}, {sv[i].e_wdata, sv[i].e_we, sv[i].e_err});
    end

    // Reset while a transaction is waiting on ack.
    mem_aluop_i = 8'hE3; mem_mem_addr_i = 32'h10C; mem_we_reg_i = 1'b1; mem_waddr_reg_i = 5'd2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    chk("wait_before_rst", {dbus_req_o, stallreq_o}, 2'b11);
    rst = 1'b1;
    #1;
    chk("rst_in_wait_outputs", {wb_waddr_reg_o, wb_we_reg_o, wb_wdata_o, stallreq_o, dbus_req_o,
        dbus_we_o, dbus_addr_o, dbus_sel_o, dbus_wdata_o, misalign_o, bus_err_o}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    nop_inputs();
    #2;
    chk("after_rst_idle", {dbus_req_o, stallreq_o, bus_err_o, dbus_sel_o}, 7'b0);
    @(posedge clk); #3;
    chk("after_rst_noreq", {dbus_req_o, stallreq_o}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
